// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared types and constants for the tone sequencer
// Contents:
//   note_t     queued note entry {dur_ms, freq_hz}; packs like the NOTE write word
//   *_ADDR     register addresses on the Avalon slave
//   CTRL_*     bit positions in the CTRL write word
//   ST_*       bit positions in the STATUS read word
//   state_t    sequencer FSM states
//   note_ms    a zero duration is played as 1 ms
package tone_seq_pkg;

  typedef struct packed {
    logic [15:0] dur_ms;
    logic [15:0] freq_hz;
  } note_t;

  localparam logic [1:0] NOTE_ADDR   = 2'd0;
  localparam logic [1:0] CTRL_ADDR   = 2'd1;
  localparam logic [1:0] STATUS_ADDR = 2'd2;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int ST_FULL    = 9;
  localparam int ST_EMPTY   = 10;
  localparam int ST_PLAYING = 11;
  localparam int ST_OVF     = 12;
  localparam int ST_RUN     = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  function automatic logic [15:0] note_ms(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - synchronous FIFO holding queued note entries
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   flush          empties the FIFO; wins over a same-cycle push
//   push, din      write request and data; dropped when full unless popping
//   pop, dout      read request and the current head entry
//   full, empty    occupancy flags
//   count          number of stored entries
module note_fifo
  import tone_seq_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = note_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, so the slot being freed is reused.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - Avalon-MM note sequencer feeding the tone generator
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   avs_address       0 NOTE(W), 1 CTRL(W), 2 STATUS(R), 3 reserved
//   avs_write         write strobe, avs_writedata write data
//   avs_read          read strobe (reads have no side effects)
//   avs_readdata      combinational read data selected by avs_address
//   tone_write        one-cycle load strobe to the tone generator
//   tone_writedata    {16'b0, freq_hz}, held between loads
//   mute              gates the speaker off during rests and idle
// FCLK/1000 must be at least 2: the LOAD cycle is the first tick of a note.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int FCLK  = 50_000_000,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        tone_write,
  output logic [31:0] tone_writedata,
  output logic        mute
);

  localparam int TICK = FCLK / 1000;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK - 1);

  state_t          state_q, state_d;
  logic            run_q;
  logic            ovf_q;
  logic [PW-1:0]   presc_q;
  logic [15:0]     ms_q;
  logic [31:0]     twd_q;
  logic            mute_q;

  note_t           head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic            note_wr;
  logic            ctrl_wr;
  logic            flush;
  logic            ovf_clr;
  logic            ovf_set;
  logic            load_fire;
  logic            note_last;
  logic            unused_read;

  assign unused_read = avs_read;

  assign note_wr = avs_write && (avs_address == NOTE_ADDR);
  assign ctrl_wr = avs_write && (avs_address == CTRL_ADDR);
  assign flush   = ctrl_wr && avs_writedata[CTRL_FLUSH];
  assign ovf_clr = ctrl_wr && avs_writedata[CTRL_OVF_CLR];
  // Only a genuinely lost note counts as overflow; a push discarded by a
  // flush is not one.
  assign ovf_set = note_wr && !flush && fifo_full && !load_fire;

  note_fifo #(.DEPTH(DEPTH), .T(note_t)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (note_wr),
    .din     (avs_writedata),
    .pop     (load_fire),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // LOAD stands for prescaler value 0, so PLAY resumes at 1 and the note
  // ends on the wrap of its final millisecond.
  assign note_last = (state_q == PLAY) && (presc_q == TICK_LAST) && (ms_q == 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_fire      = 1'b0;
    mute           = 1'b1;
    case (state_q)
      IDLE: begin
        if (run_q && !fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        load_fire = 1'b1;
        state_d   = PLAY;
      end
      PLAY: begin
        mute = mute_q;
        if (note_last) state_d = (run_q && !fifo_empty) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      load_fire = 1'b0;
    end
    if (load_fire) mute = (head.freq_hz == 16'd0);
    tone_write     = load_fire;
    tone_writedata = load_fire ? {16'b0, head.freq_hz} : twd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      ms_q    <= '0;
      twd_q   <= '0;
      mute_q  <= 1'b1;
    end else begin
      if (ctrl_wr) run_q <= avs_writedata[CTRL_RUN];
      if (ovf_clr) ovf_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      if (load_fire) begin
        presc_q <= PW'(1);
        ms_q    <= note_ms(head.dur_ms);
        twd_q   <= {16'b0, head.freq_hz};
        mute_q  <= (head.freq_hz == 16'd0);
      end else if (state_q == PLAY) begin
        if (presc_q == TICK_LAST) begin
          presc_q <= '0;
          ms_q    <= ms_q - 16'd1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (avs_address == STATUS_ADDR) begin
      avs_readdata[8:0]        = 9'(fifo_count);
      avs_readdata[ST_FULL]    = fifo_full;
      avs_readdata[ST_EMPTY]   = fifo_empty;
      avs_readdata[ST_PLAYING] = (state_q != IDLE);
      avs_readdata[ST_OVF]     = ovf_q;
      avs_readdata[ST_RUN]     = run_q;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        tone_write;
  logic [31:0] tone_writedata;
  logic        mute;

  tone_sequencer #(.FCLK(10_000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .tone_write     (tone_write),
    .tone_writedata (tone_writedata),
    .mute           (mute)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        mute;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic        mute;
    int          gap;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (reset_n === 1'b1 && tone_write === 1'b1) begin
      o.cyc  = cyc;
      o.data = tone_writedata;
      o.mute = mute;
      obs_q.push_back(o);
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_address   = 2'd2;
  endtask

  task automatic push_note(input int dur, input int freq, input bit expect_play, input int gap);
    exp_t e;
    reg_wr(2'd0, {dur[15:0], freq[15:0]});
    if (expect_play) begin
      e.data = {16'b0, freq[15:0]};
      e.mute = (freq == 0);
      e.gap  = gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic rd_status(output logic [31:0] v);
    avs_address = 2'd2;
    avs_read    = 1'b1;
    #1;
    v = avs_readdata;
    avs_read    = 1'b0;
  endtask

  task automatic get_obs(input int budget, output obs_t o, output bit got);
    got = 1'b0;
    o.cyc = -1; o.data = 'x; o.mute = 1'bx;
    for (int i = 0; i < budget && !got; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        got = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] st;
    repeat (3) @(negedge clk);
    rd_status(st);
    total++; if (mute !== 1'b1) begin bad++; $display("FAIL reset_mute got=%b exp=1", mute); end
    total++; if (tone_write !== 1'b0) begin bad++; $display("FAIL reset_tone_write got=%b exp=0", tone_write); end
    total++; if (tone_writedata !== 32'd0) begin bad++; $display("FAIL reset_twd got=%0d exp=0", tone_writedata); end
    total++; if (st !== 32'h0400) begin bad++; $display("FAIL reset_status got=%h exp=00000400", st); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_status(st);
    total++; if (mute !== 1'b1 || tone_write !== 1'b0 || tone_writedata !== 32'd0)
      begin bad++; $display("FAIL post_reset_outputs got=%b/%b/%0d exp=1/0/0", mute, tone_write, tone_writedata); end
    total++; if (st !== 32'h0400) begin bad++; $display("FAIL post_reset_status got=%h exp=00000400", st); end
  endtask

  task automatic test_sequence;
    obs_t o1, o2;
    exp_t e;
    bit got;
    logic [31:0] st;
    push_note(3, 440, 1'b1, 0);
    push_note(2, 880, 1'b1, 30);
    reg_wr(2'd1, 32'd1);
    get_obs(100, o1, got);
    e = exp_q.pop_front();
    total++; if (!got || o1.data !== e.data || o1.mute !== e.mute)
      begin bad++; $display("FAIL seq_first got=%0d mute=%b seen=%b exp=%0d mute=%b", o1.data, o1.mute, got, e.data, e.mute); end
    get_obs(100, o2, got);
    e = exp_q.pop_front();
    total++; if (!got || o2.data !== e.data || o2.mute !== e.mute)
      begin bad++; $display("FAIL seq_second got=%0d mute=%b seen=%b exp=%0d mute=%b", o2.data, o2.mute, got, e.data, e.mute); end
    total++; if (!got || (o2.cyc - o1.cyc) !== e.gap)
      begin bad++; $display("FAIL seq_gap got=%0d exp=%0d", o2.cyc - o1.cyc, e.gap); end
    wait_cyc(o2.cyc + 19);
    rd_status(st);
    total++; if (st[11] !== 1'b1 || mute !== 1'b0)
      begin bad++; $display("FAIL seq_last_cycle playing=%b mute=%b exp=1/0", st[11], mute); end
    wait_cyc(o2.cyc + 20);
    rd_status(st);
    total++; if (st[11] !== 1'b0 || mute !== 1'b1)
      begin bad++; $display("FAIL seq_idle playing=%b mute=%b exp=0/1", st[11], mute); end
    total++; if (tone_writedata !== 32'd880)
      begin bad++; $display("FAIL seq_hold_twd got=%0d exp=880", tone_writedata); end
  endtask

  task automatic test_rest_and_zero_dur;
    obs_t o;
    exp_t e;
    bit got;
    int loud;
    logic [31:0] st;
    push_note(1, 0, 1'b1, 0);
    get_obs(50, o, got);
    e = exp_q.pop_front();
    total++; if (!got || o.data !== e.data || o.mute !== e.mute)
      begin bad++; $display("FAIL rest_write got=%0d mute=%b seen=%b exp=%0d mute=%b", o.data, o.mute, got, e.data, e.mute); end
    loud = 0;
    for (int j = 1; j < 10; j++) begin
      wait_cyc(o.cyc + j);
      if (mute !== 1'b1) loud++;
    end
    total++; if (loud !== 0) begin bad++; $display("FAIL rest_mute unmuted_cycles=%0d exp=0", loud); end
    wait_cyc(o.cyc + 10);
    push_note(0, 500, 1'b1, 0);
    get_obs(50, o, got);
    e = exp_q.pop_front();
    total++; if (!got || o.data !== e.data || o.mute !== e.mute)
      begin bad++; $display("FAIL zero_dur_write got=%0d mute=%b seen=%b exp=%0d mute=%b", o.data, o.mute, got, e.data, e.mute); end
    wait_cyc(o.cyc + 9);
    rd_status(st);
    total++; if (st[11] !== 1'b1 || mute !== 1'b0)
      begin bad++; $display("FAIL zero_dur_last playing=%b mute=%b exp=1/0", st[11], mute); end
    wait_cyc(o.cyc + 10);
    rd_status(st);
    total++; if (st[11] !== 1'b0 || mute !== 1'b1)
      begin bad++; $display("FAIL zero_dur_idle playing=%b mute=%b exp=0/1", st[11], mute); end
  endtask

  task automatic test_overflow;
    logic [31:0] st;
    reg_wr(2'd1, 32'd0);
    for (int k = 0; k < 5; k++) push_note(2, 100 + k, 1'b0, 0);
    rd_status(st);
    total++; if (st !== 32'h1204) begin bad++; $display("FAIL ovf_status got=%h exp=00001204", st); end
    reg_wr(2'd1, 32'd4);
    rd_status(st);
    total++; if (st !== 32'h0204) begin bad++; $display("FAIL ovf_clear got=%h exp=00000204", st); end
    reg_wr(2'd1, 32'd2);
    rd_status(st);
    total++; if (st !== 32'h0400) begin bad++; $display("FAIL ovf_flush got=%h exp=00000400", st); end
  endtask

  task automatic test_flush;
    obs_t o;
    exp_t e;
    bit got;
    logic [31:0] st;
    push_note(5, 1000, 1'b1, 0);
    push_note(5, 1200, 1'b0, 0);
    reg_wr(2'd1, 32'd1);
    get_obs(50, o, got);
    e = exp_q.pop_front();
    total++; if (!got || o.data !== e.data)
      begin bad++; $display("FAIL flush_first got=%0d seen=%b exp=%0d", o.data, got, e.data); end
    wait_cyc(o.cyc + 10);
    reg_wr(2'd1, 32'd3);
    rd_status(st);
    total++; if (st !== 32'h2400 || mute !== 1'b1)
      begin bad++; $display("FAIL flush_idle status=%h mute=%b exp=00002400/1", st, mute); end
    repeat (60) @(negedge clk);
    #1;
    total++; if (obs_q.size() !== 0)
      begin bad++; $display("FAIL flush_no_write got=%0d writes exp=0", obs_q.size()); end
  endtask

  task automatic test_stop_and_reset;
    obs_t o;
    exp_t e;
    bit got;
    logic [31:0] st;
    push_note(4, 700, 1'b1, 0);
    push_note(2, 300, 1'b0, 0);
    get_obs(50, o, got);
    e = exp_q.pop_front();
    total++; if (!got || o.data !== e.data)
      begin bad++; $display("FAIL stop_first got=%0d seen=%b exp=%0d", o.data, got, e.data); end
    wait_cyc(o.cyc + 5);
    reg_wr(2'd1, 32'd0);
    wait_cyc(o.cyc + 39);
    rd_status(st);
    total++; if (st[11] !== 1'b1 || mute !== 1'b0)
      begin bad++; $display("FAIL stop_last playing=%b mute=%b exp=1/0", st[11], mute); end
    wait_cyc(o.cyc + 40);
    rd_status(st);
    total++; if (st !== 32'h0001 || mute !== 1'b1)
      begin bad++; $display("FAIL stop_idle status=%h mute=%b exp=00000001/1", st, mute); end
    repeat (15) @(negedge clk);
    #1;
    total++; if (obs_q.size() !== 0)
      begin bad++; $display("FAIL stop_no_pop got=%0d writes exp=0", obs_q.size()); end
    e.data = 32'd300; e.mute = 1'b0; e.gap = 0;
    exp_q.push_back(e);
    reg_wr(2'd1, 32'd1);
    get_obs(50, o, got);
    e = exp_q.pop_front();
    total++; if (!got || o.data !== e.data)
      begin bad++; $display("FAIL restart_write got=%0d seen=%b exp=%0d", o.data, got, e.data); end
    wait_cyc(o.cyc + 5);
    reset_n = 1'b0;
    #1;
    rd_status(st);
    total++; if (mute !== 1'b1 || tone_write !== 1'b0 || tone_writedata !== 32'd0 || st !== 32'h0400)
      begin bad++; $display("FAIL midnote_reset mute=%b tw=%b twd=%0d status=%h exp=1/0/0/00000400", mute, tone_write, tone_writedata, st); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total++; if (obs_q.size() !== 0 || exp_q.size() !== 0)
      begin bad++; $display("FAIL scoreboard_drain obs=%0d exp=%0d required=0/0", obs_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_rest_and_zero_dur;
    test_overflow;
    test_flush;
    test_stop_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
